// File: rtl/contador_pontos_multi.sv
`default_nettype none
// =============================================================================
// Module      : contador_pontos_multi
// Description : N-channel saturating score counter with blocked-line tracking
//               (hysteresis on release). Optional streak bonus is enabled by
//               defining CONTADOR_SEQUENCIA_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module contador_pontos_multi #(
    parameter int N_JOG      = 2,
    parameter int W          = 6,
    parameter int PONTOS_MAX = 32,
    parameter int PASSO      = 4,
    parameter int LINHAS_MAX = 7,
    parameter int HIST       = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               zerar,
    input  logic [N_JOG-1:0]   acertou,
    input  logic [N_JOG-1:0]   errou,
    output logic [N_JOG*W-1:0] pontos,
    output logic [N_JOG*3-1:0] linhas_bloq,
    output logic [N_JOG-1:0]   linha_mudou,
    output logic [N_JOG-1:0]   maximo
);

    localparam logic [W-1:0] c_MAX   = W'(PONTOS_MAX);
    localparam logic [W-1:0] c_UM    = W'(1);
    localparam logic [2:0]   c_LMAX  = 3'(LINHAS_MAX);

    genvar i;
    generate
        for (i = 0; i < N_JOG; i++) begin : g_ch
            logic         r_ac;
            logic         r_ac_d;
            logic         r_er;
            logic         r_er_d;
            logic         w_hit;
            logic         w_miss;
            logic [1:0]   w_inc;
            logic [W:0]   w_soma;
            logic [W-1:0] w_score_nxt;
            logic [W-1:0] r_score;
            logic [2:0]   r_linhas;
            logic         r_mudou;
            logic         w_sobe;
            logic         w_desce;

            // Sampled copies are delayed once more, so the event appears the
            // cycle after the input is first seen high.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_ac   <= 1'b1;
                    r_ac_d <= 1'b1;
                    r_er   <= 1'b1;
                    r_er_d <= 1'b1;
                end else begin
                    r_ac   <= acertou[i];
                    r_ac_d <= r_ac;
                    r_er   <= errou[i];
                    r_er_d <= r_er;
                end
            end

            assign w_hit  = r_ac & ~r_ac_d;
            assign w_miss = r_er & ~r_er_d;

`ifdef CONTADOR_SEQUENCIA_EN
            logic [1:0] r_seq;

            assign w_inc = (r_seq == 2'd2) ? 2'd2 : 2'd1;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_seq <= 2'd0;
                end else if (zerar) begin
                    r_seq <= 2'd0;
                end else if (enable) begin
                    if (w_hit && !w_miss)
                        r_seq <= (r_seq == 2'd2) ? 2'd0 : r_seq + 2'd1;
                    else if (w_miss)
                        r_seq <= 2'd0;
                end
            end
`else
            assign w_inc = 2'd1;
`endif

            assign w_soma = {1'b0, r_score} + {{(W-1){1'b0}}, w_inc};

            always_comb begin
                w_score_nxt = r_score;
                if (enable) begin
                    if (w_hit && !w_miss)
                        w_score_nxt = (w_soma >= {1'b0, c_MAX}) ? c_MAX : w_soma[W-1:0];
                    else if (w_miss && !w_hit)
                        w_score_nxt = (r_score == '0) ? '0 : r_score - c_UM;
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    r_score <= '0;
                else if (zerar)
                    r_score <= '0;
                else
                    r_score <= w_score_nxt;
            end

            // Release threshold is lowered by HIST; evaluated in int to
            // avoid underflow when HIST >= PASSO.
            always_comb begin
                w_sobe  = (r_linhas < c_LMAX) &&
                          (int'(r_score) >= (int'(r_linhas) + 1) * PASSO);
                w_desce = (r_linhas != 3'd0) &&
                          (int'(r_score) + HIST < int'(r_linhas) * PASSO);
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_linhas <= 3'd0;
                    r_mudou  <= 1'b0;
                end else if (zerar) begin
                    r_linhas <= 3'd0;
                    r_mudou  <= (r_linhas != 3'd0);
                end else if (r_score == '0 && r_linhas != 3'd0) begin
                    r_linhas <= 3'd0;
                    r_mudou  <= 1'b1;
                end else if (w_sobe) begin
                    r_linhas <= r_linhas + 3'd1;
                    r_mudou  <= 1'b1;
                end else if (w_desce) begin
                    r_linhas <= r_linhas - 3'd1;
                    r_mudou  <= 1'b1;
                end else begin
                    r_mudou  <= 1'b0;
                end
            end

            assign pontos[i*W +: W]      = r_score;
            assign linhas_bloq[i*3 +: 3] = r_linhas;
            assign linha_mudou[i]        = r_mudou;
            assign maximo[i]             = (r_score == c_MAX);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_contador_pontos_multi.sv
`default_nettype none
// =============================================================================
// Module      : tb_contador_pontos_multi
// Description : Directed self-checking bench for contador_pontos_multi.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_contador_pontos_multi;

    localparam int N = 2;
    localparam int W = 6;

    logic           clock   = 1'b0;
    logic           reset   = 1'b0;
    logic           enable  = 1'b1;
    logic           zerar   = 1'b0;
    logic [N-1:0]   acertou = '0;
    logic [N-1:0]   errou   = '0;
    logic [N*W-1:0] pontos;
    logic [N*3-1:0] linhas_bloq;
    logic [N-1:0]   linha_mudou;
    logic [N-1:0]   maximo;

    contador_pontos_multi #(
        .N_JOG(N), .W(W), .PONTOS_MAX(32), .PASSO(4), .LINHAS_MAX(7), .HIST(1)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .zerar(zerar),
        .acertou(acertou), .errou(errou), .pontos(pontos),
        .linhas_bloq(linhas_bloq), .linha_mudou(linha_mudou), .maximo(maximo)
    );

    always #5 clock = ~clock;

    int vec  = 0;
    int errs = 0;
    int exp_pts [N];
    int exp_seq [N];
    int n_mud0  = 0;

    logic [W-1:0] p0, p1;
    logic [2:0]   l0, l1;
    assign p0 = pontos[W-1:0];
    assign p1 = pontos[2*W-1:W];
    assign l0 = linhas_bloq[2:0];
    assign l1 = linhas_bloq[5:3];

    always @(negedge clock) if (linha_mudou[0]) n_mud0++;

    // Drives one 1-cycle strobe (called at a negedge) and advances the score
    // model; returns at the negedge where the new score is visible.
    task automatic pulse(input int ch, input bit h, input bit m);
        int inc;
        acertou[ch] = h;
        errou[ch]   = m;
        if (zerar) begin
            for (int k = 0; k < N; k++) begin
                exp_pts[k] = 0;
                exp_seq[k] = 0;
            end
        end else if (enable) begin
            if (h && !m) begin
`ifdef CONTADOR_SEQUENCIA_EN
                inc = (exp_seq[ch] == 2) ? 2 : 1;
                exp_seq[ch] = (exp_seq[ch] == 2) ? 0 : exp_seq[ch] + 1;
`else
                inc = 1;
`endif
                exp_pts[ch] = (exp_pts[ch] + inc > 32) ? 32 : exp_pts[ch] + inc;
            end else if (m) begin
                if (!h) exp_pts[ch] = (exp_pts[ch] == 0) ? 0 : exp_pts[ch] - 1;
                exp_seq[ch] = 0;
            end
        end
        @(negedge clock);
        acertou[ch] = 1'b0;
        errou[ch]   = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        vec++; if (pontos !== '0) begin errs++; $display("FAIL reset_pontos: got %h expected 0", pontos); end
        vec++; if (linhas_bloq !== '0) begin errs++; $display("FAIL reset_linhas: got %h expected 0", linhas_bloq); end
        vec++; if (linha_mudou !== '0) begin errs++; $display("FAIL reset_mudou: got %b expected 0", linha_mudou); end
        vec++; if (maximo !== '0) begin errs++; $display("FAIL reset_maximo: got %b expected 0", maximo); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        vec++; if (pontos !== '0) begin errs++; $display("FAIL post_release_pontos: got %h expected 0", pontos); end
    endtask

    task automatic test_hits();
        n_mud0 = 0;
        for (int k = 0; k < 4; k++) begin
            pulse(0, 1'b1, 1'b0);
            vec++; if (int'(p0) !== exp_pts[0]) begin errs++; $display("FAIL hit%0d_p0: got %0d expected %0d", k, p0, exp_pts[0]); end
        end
        @(negedge clock); @(negedge clock); #1;
        vec++; if (l0 !== 3'd1) begin errs++; $display("FAIL hits_l0: got %0d expected 1", l0); end
        vec++; if (n_mud0 !== 1) begin errs++; $display("FAIL hits_mudou_pulses: got %0d expected 1", n_mud0); end
        vec++; if (p1 !== '0 || l1 !== 3'd0) begin errs++; $display("FAIL hits_ch1_idle: got p=%0d l=%0d expected 0 0", p1, l1); end
    endtask

    task automatic test_misses();
        while (exp_pts[0] < 8) pulse(0, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        vec++; if (p0 !== 6'd8 || l0 !== 3'd2) begin errs++; $display("FAIL start8: got p=%0d l=%0d expected 8 2", p0, l0); end
        n_mud0 = 0;
        pulse(0, 1'b0, 1'b1);
        @(negedge clock);
        vec++; if (p0 !== 6'd7 || l0 !== 3'd2) begin errs++; $display("FAIL hyst7: got p=%0d l=%0d expected 7 2", p0, l0); end
        pulse(0, 1'b0, 1'b1);
        @(negedge clock); #1;
        vec++; if (p0 !== 6'd6 || l0 !== 3'd1) begin errs++; $display("FAIL drop6: got p=%0d l=%0d expected 6 1", p0, l0); end
        vec++; if (n_mud0 !== 1) begin errs++; $display("FAIL drop6_pulses: got %0d expected 1", n_mud0); end
        @(negedge clock);
        repeat (6) pulse(0, 1'b0, 1'b1);
        @(negedge clock);
        vec++; if (p0 !== 6'd0 || l0 !== 3'd0) begin errs++; $display("FAIL floor0: got p=%0d l=%0d expected 0 0", p0, l0); end
        pulse(0, 1'b0, 1'b1);
        vec++; if (p0 !== 6'd0) begin errs++; $display("FAIL floor_hold: got %0d expected 0", p0); end
    endtask

    task automatic test_saturation();
        repeat (40) pulse(1, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        vec++; if (p1 !== 6'd32) begin errs++; $display("FAIL sat_p1: got %0d expected 32", p1); end
        vec++; if (maximo !== 2'b10) begin errs++; $display("FAIL sat_maximo: got %b expected 10", maximo); end
        vec++; if (l1 !== 3'd7) begin errs++; $display("FAIL sat_l1: got %0d expected 7", l1); end
        pulse(1, 1'b0, 1'b1);
        @(negedge clock);
        vec++; if (p1 !== 6'd31 || maximo[1] !== 1'b0 || l1 !== 3'd7) begin errs++; $display("FAIL sat_miss: got p=%0d max=%b l=%0d expected 31 0 7", p1, maximo[1], l1); end
        vec++; if (p0 !== 6'd0) begin errs++; $display("FAIL sat_ch0_idle: got %0d expected 0", p0); end
    endtask

    task automatic test_conflicts();
        while (exp_pts[0] < 5) pulse(0, 1'b1, 1'b0);
        vec++; if (p0 !== 6'd5) begin errs++; $display("FAIL conf_start5: got %0d expected 5", p0); end
        pulse(0, 1'b1, 1'b1);
        vec++; if (p0 !== 6'd5) begin errs++; $display("FAIL hit_and_miss: got %0d expected 5", p0); end
        enable = 1'b0;
        pulse(0, 1'b1, 1'b0);
        enable = 1'b1;
        vec++; if (p0 !== 6'd5) begin errs++; $display("FAIL enable_low: got %0d expected 5", p0); end
        @(negedge clock);
        vec++; if (l0 !== 3'd1) begin errs++; $display("FAIL conf_l0: got %0d expected 1", l0); end
        zerar = 1'b1;
        pulse(0, 1'b1, 1'b0);
        zerar = 1'b0;
        @(negedge clock);
        vec++; if (pontos !== '0 || linhas_bloq !== '0) begin errs++; $display("FAIL zerar_hit: got p=%h l=%h expected 0 0", pontos, linhas_bloq); end
    endtask

    task automatic test_streak();
        bit ops [8];
        int ex  [8];
        ops = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef CONTADOR_SEQUENCIA_EN
        ex = '{1, 2, 4, 5, 4, 5, 6, 8};
`else
        ex = '{1, 2, 3, 4, 3, 4, 5, 6};
`endif
        for (int k = 0; k < 8; k++) begin
            pulse(0, ops[k], !ops[k]);
            vec++; if (int'(p0) !== ex[k]) begin errs++; $display("FAIL streak%0d: got %0d expected %0d", k, p0, ex[k]); end
        end
    endtask

    task automatic test_async_reset();
        while (exp_pts[1] < 12) pulse(1, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        vec++; if (p1 !== 6'd12 || l1 !== 3'd3) begin errs++; $display("FAIL pre_reset: got p=%0d l=%0d expected 12 3", p1, l1); end
        #2 reset = 1'b0;
        acertou[1] = 1'b1;
        #1;
        vec++; if (pontos !== '0 || linhas_bloq !== '0 || linha_mudou !== '0 || maximo !== '0) begin
            errs++; $display("FAIL async_reset: got p=%h l=%h m=%b x=%b expected all 0", pontos, linhas_bloq, linha_mudou, maximo);
        end
        for (int k = 0; k < N; k++) begin exp_pts[k] = 0; exp_seq[k] = 0; end
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        vec++; if (p1 !== 6'd0) begin errs++; $display("FAIL held_high: got %0d expected 0", p1); end
        acertou[1] = 1'b0;
        @(negedge clock);
        pulse(1, 1'b1, 1'b0);
        vec++; if (p1 !== 6'd1) begin errs++; $display("FAIL after_refall: got %0d expected 1", p1); end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin exp_pts[k] = 0; exp_seq[k] = 0; end
        test_reset();
        test_hits();
        test_misses();
        test_saturation();
        test_conflicts();
        test_streak();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/contador_pontos_multi.md
# contador_pontos_multi

Clocked, parametrised multi-player score counter with blocked-line tracking. Each player channel takes hit/miss strobes from the game datapath, keeps a saturating score, and derives how many lines of that player's board are blocked, using hysteresis on the way down. Sits between the per-player answer checkers and the display/board controllers. It replaces the unclocked single-player edge-triggered counter.

## Interface
- `N_JOG`, 2: number of independent player channels (1..8).
- `W`, 6: score width per channel.
- `PONTOS_MAX`, 32: saturation ceiling (< 2^W).
- `PASSO`, 4: points per blocked line.
- `LINHAS_MAX`, 7: ceiling of blocked lines per channel.
- `HIST`, 1: hysteresis, in points, applied when a line is released.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when low, edges are detected but ignored (no score change).
- `zerar`  in  1  synchronous clear of all scores, lines and streaks.
- `acertou`  in  N_JOG  per-channel hit level; a rising edge counts as one hit.
- `errou`  in  N_JOG  per-channel miss level; a rising edge counts as one miss.
- `pontos`  out  N_JOG*W  packed scores; channel i occupies bits [i*W +: W].
- `linhas_bloq`  out  N_JOG*3  packed blocked-line counts; channel i occupies bits [i*3 +: 3].
- `linha_mudou`  out  N_JOG  one-cycle pulse when that channel's `linhas_bloq` changes.
- `maximo`  out  N_JOG  level, high while that channel's score equals PONTOS_MAX.

## Operation
- Edge detect per channel and input: `acertou_d` and `errou_d` are registered copies. A hit event is `acertou & ~acertou_d`; a miss event is `errou & ~errou_d`. The `_d` registers reset to 1, so an input held high through reset release is not counted.
- Score update applies only when `enable`=1:
  - hit only: score + inc, saturated at PONTOS_MAX.
  - miss only: score - 1, floored at 0.
  - hit and miss in the same cycle: no change, and the streak is cleared.
- inc = 1, except as described under Configuration.
- Line controller per channel, with L = current `linhas_bloq`:
  - up: if L < LINHAS_MAX and score >= (L+1)*PASSO, then L+1.
  - down: if L > 0 and score < L*PASSO - HIST, then L-1.
  - score = 0 forces L = 0.
  - L moves by at most one step per cycle. Multi-step changes converge over successive cycles, with one `linha_mudou` pulse per step.
- `zerar` has priority over any event in the same cycle. It clears score, L and streak, and keeps the edge registers. It produces `linha_mudou`=1 for one cycle on channels whose L was nonzero.
- Channels are fully independent. No cross-channel arithmetic.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

## Timing
- Reset values: `pontos`=0, `linhas_bloq`=0, `linha_mudou`=0, `maximo`=0; internal streaks = 0; edge registers = 1.
- An input sampled high at edge t, and low at edge t-1, updates `pontos` at edge t+1. Latency is 1 cycle from the sampled edge.
- `linhas_bloq` and `linha_mudou` update one edge after the `pontos` value that causes them.
- `maximo` is decoded combinationally from the registered score.
- Minimum spacing between events on one input: 2 cycles (high 1, low 1). Faster toggling is outside the contract.
- Inputs are assumed synchronous to `clock`. Synchronisers are the instantiating module's responsibility.

## Configuration
- `CONTADOR_SEQUENCIA_EN` defined: a per-channel 2-bit streak counter tracks consecutive hits.
  - A hit that arrives with streak = 2 adds 2 points (still saturated) and resets the streak to 0.
  - Any other hit increments the streak.
  - A miss, a simultaneous hit+miss, or `zerar` clears the streak.
- `CONTADOR_SEQUENCIA_EN` undefined: no streak logic is synthesised and every hit adds exactly 1.

## Test plan
- Reset, then 4 single hits on channel 0 -> `pontos[0]`=4. `linhas_bloq[0]`=1 one cycle later, with one `linha_mudou[0]` pulse. Channel 1 stays at 0.
- Starting from score 8 (L=2), miss -> score 7, L=2 (held by hysteresis); miss -> score 6, L=1 with a pulse; 6 more misses -> score 0, L=0, further misses keep 0.
- 40 hits on channel 1 -> score stops at 32, `maximo[1]`=1, L=7. One miss -> 31, `maximo[1]`=0, L stays 7.
- Hit and miss rising in the same cycle at score 5 -> score stays 5. `enable`=0 during one hit -> no change. `zerar` together with a hit -> score 0, L 0.
- With `CONTADOR_SEQUENCIA_EN`: hit, hit, hit from 0 -> scores 1, 2, 4; hit, miss, hit, hit, hit -> 5, 4, 5, 6, 8. Without the macro the same stimulus gives 1, 2, 3.
- Assert `reset` low mid-sequence at score 12, L=3 -> all outputs 0 with no clock edge. An input held high across release -> no count until it falls and rises again.
